fft_stage_ctrl: RTL
===================

# fft_stage_ctrl

Per-stage sequencer for the in-place radix-2 DIT FFT core. It walks every stage and every butterfly, and generates the following:
- ping-pong RAM read addresses;
- the twiddle index and enable for the `multComplexE` twiddle multiplier;
- delay-matched write-back addresses.

It sits between the FFT top-level start/done handshake and the working-RAM plus butterfly datapath. It guarantees that no stage reads a location before the previous stage has written it.

## Interface

Parameters:
- `SIZE_DATA_FI`, default 3: log2(NFFT); legal range 2..8.
- `RD_LAT`, default 1: RAM read latency in cycles, from `o_rd_en` to data at the multiplier input; legal range 1..4.
- `MULT_LAT`, default 5: multiplier latency in cycles, from `o_mult_en` to a valid butterfly result at the RAM write port; legal range 1..8.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when the last stage's writes are complete.
- `o_stage`  out  4  current stage index, 0..SIZE_DATA_FI-1.
- `o_bank`  out  1  read bank select; the write bank is `~o_bank`.
- `o_rd_en`  out  1  butterfly read strobe.
- `o_rd_addr_a`  out  SIZE_DATA_FI  upper-wing read address.
- `o_rd_addr_b`  out  SIZE_DATA_FI  lower-wing read address.
- `o_mult_en`  out  1  multiplier enable; drives the multiplier's `i_en`.
- `o_fi_deg`  out  16  twiddle index, zero-extended, valid with `o_mult_en`; bits [SIZE_DATA_FI-2:0] are significant.
- `o_wr_en`  out  1  write-back strobe.
- `o_wr_addr_a`  out  SIZE_DATA_FI  write address for the upper wing.
- `o_wr_addr_b`  out  SIZE_DATA_FI  write address for the lower wing.

## Operation

Notation: N = 2^SIZE_DATA_FI, L = SIZE_DATA_FI, D = RD_LAT + MULT_LAT.

FSM states:
- IDLE → RUN on `i_start`. Clears the butterfly counter k, sets `o_stage` = 0 and `o_bank` = 0.
- RUN: issues one butterfly per cycle, k = 0..N/2-1, with `o_rd_en` = 1. After k = N/2-1, goes to DRAIN.
- DRAIN: lasts D cycles with `o_rd_en` = 0. On exit:
  - if `o_stage` == L-1, goes to DONE;
  - otherwise increments `o_stage`, toggles `o_bank`, clears k and returns to RUN.
- DONE: lasts one cycle with `o_done` = 1, then goes to IDLE.

Address generation for stage s and counter k:
- half = 2^s
- p = k & (half-1)
- a = ((k >> s) << (s+1)) | p
- b = a + half
- fi = p << (L-1-s), which is always < N/2.

Pipelining:
- `o_fi_deg` and `o_mult_en` are `o_rd_en` and its fi delayed by RD_LAT registers.
- `o_wr_en`, `o_wr_addr_a` and `o_wr_addr_b` are `o_rd_en`, a and b delayed by D registers.
- Delay lines are shift registers, one entry per cycle, with no stall input.
- `o_fi_deg` and the write addresses hold their last value when their strobe is low. Only the strobes are qualifying.

Boundaries and rules:
- `i_start` during `o_busy` is ignored. No restart and no queueing.
- `i_reset` in any state:
  - next cycle the FSM is in IDLE and every output is 0;
  - all delay-line valid bits are cleared, so in-flight writes are dropped;
  - `i_reset` has priority over `i_start` in the same cycle.
- L = 2: one-butterfly-per-cycle sequencing is unchanged and fi is always 0 or 1.
- Counter k wraps only through the RUN→DRAIN exit; it never exceeds N/2-1.

Reset values: every output is 0, the FSM is in IDLE, and all delay-line contents are 0.

## Timing

- `i_start` is sampled at edge 0 and RUN begins in cycle 1.
- Reads for stage s occupy cycles 1 + s(N/2+D) through s(N/2+D) + N/2.
- `o_mult_en` lags `o_rd_en` by exactly RD_LAT cycles.
- `o_wr_en` lags `o_rd_en` by exactly D cycles.
- The last write of a stage falls in the last DRAIN cycle. The next stage's first read is the following cycle, so there is no read-before-write hazard.
- `o_done` is high in cycle L(N/2+D) + 1 and `o_busy` falls in the next cycle.
- `o_mult_en` has at most N/2 consecutive high cycles, then D low cycles. This matches the multiplier's continuous-enable mode.

## Test plan

All scenarios use N = 8, RD_LAT = 1, MULT_LAT = 5 (D = 6).

1. **Reset values.** Assert `i_reset` for 3 cycles → every output is 0; `i_start` in the same cycle as reset is ignored.
2. **Stage 0 addresses.** Start → cycles 1..4 show (a, b) = (0,1), (2,3), (4,5), (6,7) with fi = 0; `o_mult_en` in cycles 2..5; `o_wr_en` in cycles 7..10 with the same (a, b) order; `o_bank` = 0.
3. **Stages 1 and 2.**
   - Stage 1 reads in cycles 11..14: (0,2,fi0), (1,3,fi2), (4,6,fi0), (5,7,fi2); `o_bank` = 1.
   - Stage 2 reads in cycles 21..24: (0,4,0), (1,5,1), (2,6,2), (3,7,3); `o_bank` = 0.
   - `o_done` in cycle 31, `o_busy` low in cycle 32.
4. **Start while busy.** Pulse `i_start` again at cycle 12 → the sequence is unchanged and a single `o_done` occurs in cycle 31.
5. **Reset mid-operation.** Assert `i_reset` at cycle 8 → no `o_wr_en` in cycles 9 and 10, and all outputs are 0. A new `i_start` then reproduces scenario 2 exactly.
6. **Minimum size.** Set N = 4 (SIZE_DATA_FI = 2) → stage 0 reads (0,1), (2,3) with fi 0; stage 1 reads (0,2,0), (1,3,1); `o_done` in cycle 2·(2+6) + 1 = 17.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT: ping-pong read
// addresses, twiddle index for the multiplier and delay-matched write-back addresses.
module fft_stage_ctrl #(
  parameter int SIZE_DATA_FI = 3,
  parameter int RD_LAT       = 1,
  parameter int MULT_LAT     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [3:0]              o_stage,
  output logic                    o_bank,
  output logic                    o_rd_en,
  output logic [SIZE_DATA_FI-1:0] o_rd_addr_a,
  output logic [SIZE_DATA_FI-1:0] o_rd_addr_b,
  output logic                    o_mult_en,
  output logic [15:0]             o_fi_deg,
  output logic                    o_wr_en,
  output logic [SIZE_DATA_FI-1:0] o_wr_addr_a,
  output logic [SIZE_DATA_FI-1:0] o_wr_addr_b
);

  localparam int L  = SIZE_DATA_FI;
  localparam int KW = L - 1;
  localparam int D  = RD_LAT + MULT_LAT;
  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [3:0]    STAGE_LAST = 4'(L - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(D - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Upper-wing address: insert a zero at bit position s of the butterfly counter.
  function automatic logic [L-1:0] wing_a(input logic [3:0] s, input logic [KW-1:0] k);
    logic [L-1:0] kw;
    logic [L-1:0] mask;
    kw   = {1'b0, k};
    mask = (L'(1) << s) - L'(1);
    return ((kw >> s) << (s + 4'd1)) | (kw & mask);
  endfunction

  function automatic logic [L-1:0] wing_b(input logic [3:0] s, input logic [KW-1:0] k);
    return wing_a(s, k) | (L'(1) << s);
  endfunction

  function automatic logic [KW-1:0] twiddle(input logic [3:0] s, input logic [KW-1:0] k);
    logic [KW-1:0] mask;
    mask = (KW'(1) << s) - KW'(1);
    return (k & mask) << (STAGE_LAST - s);
  endfunction

  state_t          state_r, state_nxt_s;
  logic [KW-1:0]   k_r, k_nxt_s;
  logic [3:0]      stage_r, stage_nxt_s;
  logic            bank_r, bank_nxt_s;
  logic [3:0]      dcnt_r, dcnt_nxt_s;
  logic            busy_r, done_r;
  logic            rd_en_nxt_s;
  logic [L-1:0]    a_nxt_s, b_nxt_s;
  logic [KW-1:0]   fi_nxt_s;

  logic [D:0]      v_sr;
  logic [L-1:0]    a_sr  [0:D];
  logic [L-1:0]    b_sr  [0:D];
  logic [KW-1:0]   fi_sr [0:RD_LAT];

  // Next-state logic: stage/butterfly walk with a fixed-length drain per stage.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    stage_nxt_s = stage_r;
    bank_nxt_s  = bank_r;
    dcnt_nxt_s  = dcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_RUN;
          k_nxt_s     = {KW{1'b0}};
          stage_nxt_s = 4'd0;
          bank_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ST_DRAIN;
          dcnt_nxt_s  = 4'd0;
        end else begin
          k_nxt_s = k_r + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_r == DRAIN_LAST) begin
          if (stage_r == STAGE_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
            stage_nxt_s = stage_r + 4'd1;
            bank_nxt_s  = ~bank_r;
            k_nxt_s     = {KW{1'b0}};
          end
        end else begin
          dcnt_nxt_s = dcnt_r + 4'd1;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read-side values are computed from the next state so the read strobe is a flop.
  always_comb begin
    rd_en_nxt_s = (state_nxt_s == ST_RUN);
    a_nxt_s     = wing_a(stage_nxt_s, k_nxt_s);
    b_nxt_s     = wing_b(stage_nxt_s, k_nxt_s);
    fi_nxt_s    = twiddle(stage_nxt_s, k_nxt_s);
  end

  // FSM and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      k_r     <= {KW{1'b0}};
      stage_r <= 4'd0;
      bank_r  <= 1'b0;
      dcnt_r  <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      stage_r <= stage_nxt_s;
      bank_r  <= bank_nxt_s;
      dcnt_r  <= dcnt_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Delay lines; the tap stages only load on a valid entry so outputs hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v_sr <= {(D + 1){1'b0}};
      for (int i = 0; i <= D; i++) begin
        a_sr[i] <= {L{1'b0}};
        b_sr[i] <= {L{1'b0}};
      end
      for (int i = 0; i <= RD_LAT; i++) begin
        fi_sr[i] <= {KW{1'b0}};
      end
    end else begin
      v_sr <= {v_sr[D-1:0], rd_en_nxt_s};
      if (rd_en_nxt_s) begin
        a_sr[0]  <= a_nxt_s;
        b_sr[0]  <= b_nxt_s;
        fi_sr[0] <= fi_nxt_s;
      end
      for (int i = 1; i <= D; i++) begin
        if (i < D || v_sr[i-1]) begin
          a_sr[i] <= a_sr[i-1];
          b_sr[i] <= b_sr[i-1];
        end
      end
      for (int i = 1; i <= RD_LAT; i++) begin
        if (i < RD_LAT || v_sr[i-1]) begin
          fi_sr[i] <= fi_sr[i-1];
        end
      end
    end
  end

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_stage     = stage_r;
  assign o_bank      = bank_r;
  assign o_rd_en     = v_sr[0];
  assign o_rd_addr_a = a_sr[0];
  assign o_rd_addr_b = b_sr[0];
  assign o_mult_en   = v_sr[RD_LAT];
  assign o_fi_deg    = 16'(fi_sr[RD_LAT]);
  assign o_wr_en     = v_sr[D];
  assign o_wr_addr_a = a_sr[D];
  assign o_wr_addr_b = b_sr[D];

endmodule
